// File: rtl/viterbi_sched.sv
// Sequencing controller for the rate-1/2 K=3 Viterbi datapath: paces symbol intake,
// drives ACS/survivor writes, and runs block traceback reads over the survivor ring.
module viterbi_sched #(
  parameter int TB_DEPTH = 16,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              acs_clr,
  output logic              acs_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic              tb_rd_en,
  output logic [ADDR_W-1:0] tb_rd_addr,
  output logic              tb_first,
  output logic              tb_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ACS, S_TRACE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] tb_ptr_q, tb_ptr_d;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0]  tb_cnt_q, tb_cnt_d;
  logic [CNT_W-1:0]  tb_len_q, tb_len_d;
  logic              last_flag_q, last_flag_d;

  logic             accept;
  logic             blk_end;
  logic             tb_end;
  logic [CNT_W-1:0] step_inc;

  assign accept   = (state_q == S_ACS) & in_valid;
  assign step_inc = step_cnt_q + CNT_ONE;
  // A block closes on the pair that fills it or on the frame's last pair.
  assign blk_end  = accept & ((step_inc == DEPTH_C) | in_last);
  assign tb_end   = (state_q == S_TRACE) & (tb_cnt_q == (tb_len_q - CNT_ONE));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    tb_ptr_d    = tb_ptr_q;
    step_cnt_d  = step_cnt_q;
    tb_cnt_d    = tb_cnt_q;
    tb_len_d    = tb_len_q;
    last_flag_d = last_flag_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        wr_ptr_d   = '0;
        step_cnt_d = '0;
        state_d    = S_ACS;
      end
      S_ACS: begin
        if (accept) begin
          wr_ptr_d   = wr_ptr_q + PTR_ONE;
          step_cnt_d = step_inc;
          if (blk_end) begin
            // Traceback starts from the survivor entry written by this very pair.
            tb_ptr_d    = wr_ptr_q;
            tb_len_d    = step_inc;
            tb_cnt_d    = '0;
            last_flag_d = in_last;
            state_d     = S_TRACE;
          end
        end
      end
      S_TRACE: begin
        tb_ptr_d = tb_ptr_q - PTR_ONE;
        tb_cnt_d = tb_cnt_q + CNT_ONE;
        if (tb_end) begin
          if (last_flag_q) begin
            state_d = S_DONE;
          end else begin
            step_cnt_d = '0;
            state_d    = S_ACS;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      tb_ptr_q    <= '0;
      step_cnt_q  <= '0;
      tb_cnt_q    <= '0;
      tb_len_q    <= '0;
      last_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      tb_ptr_q    <= tb_ptr_d;
      step_cnt_q  <= step_cnt_d;
      tb_cnt_q    <= tb_cnt_d;
      tb_len_q    <= tb_len_d;
      last_flag_q <= last_flag_d;
    end
  end

  assign in_ready    = (state_q == S_ACS);
  assign acs_clr     = (state_q == S_INIT);
  assign acs_en      = accept;
  assign mem_wr_en   = accept;
  assign mem_wr_addr = wr_ptr_q;
  assign tb_rd_en    = (state_q == S_TRACE);
  assign tb_rd_addr  = tb_ptr_q;
  assign tb_first    = (state_q == S_TRACE) & (tb_cnt_q == '0);
  assign tb_last     = tb_end;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_DONE);

endmodule

// File: doc/viterbi_sched.md
# viterbi_sched

Sequencing controller for the rate-1/2, K=3 Viterbi decoder datapath. It accepts received symbol pairs over a valid/ready handshake and fires the ACS update for each accepted pair. It also generates survivor-memory write addresses and runs block-based traceback reads once TB_DEPTH trellis steps are stored or the frame ends. It sits between the symbol input stage and the bmc/ACS/survivor-memory datapath, and owns all of that datapath's enables and addresses.

## Interface
- TB_DEPTH, 16, trellis steps per traceback block (≥1, ≤ 2**ADDR_W)
- ADDR_W, 5, survivor-memory address width; ring of 2**ADDR_W entries
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  frame start pulse; honoured only in IDLE
- in_valid  input  1  rx_pair valid (pair data routed directly to bmc units)
- in_last  input  1  qualifies the accepted pair as last of frame
- in_ready  output  1  controller accepts a pair this cycle
- acs_clr  output  1  clear all path metrics
- acs_en  output  1  ACS units update this cycle
- mem_wr_en  output  1  write survivor decisions
- mem_wr_addr  output  ADDR_W  survivor write address
- tb_rd_en  output  1  traceback read strobe
- tb_rd_addr  output  ADDR_W  traceback read address
- tb_first  output  1  first read of a traceback block
- tb_last  output  1  final read of a traceback block
- busy  output  1  state ≠ IDLE
- frame_done  output  1  one-cycle pulse, frame fully traced back

## Operation
- States: IDLE, INIT, ACS, TRACE, DONE. Registers: wr_ptr, tb_ptr (ADDR_W), step_cnt, tb_cnt, tb_len (clog2(TB_DEPTH+1)), last_flag.
- IDLE: in_ready=0. start=1 → INIT. in_valid ignored.
- INIT (1 cycle): acs_clr=1, wr_ptr←0, step_cnt←0 → ACS.
- ACS: in_ready=1. Accept = in_valid & in_ready. acs_en = mem_wr_en = accept (combinational), mem_wr_addr = wr_ptr. On accept: wr_ptr←wr_ptr+1 mod 2**ADDR_W, step_cnt←step_cnt+1.
- ACS exit on accept when step_cnt+1 == TB_DEPTH or in_last=1 → TRACE. Load tb_ptr←wr_ptr (address just written), tb_len←step_cnt+1, tb_cnt←0, last_flag←in_last.
- TRACE: in_ready=0, tb_rd_en=1, tb_rd_addr=tb_ptr, tb_first=(tb_cnt==0), tb_last=(tb_cnt==tb_len-1). Each cycle tb_ptr←tb_ptr-1 mod 2**ADDR_W (0 wraps to 2**ADDR_W-1), tb_cnt←tb_cnt+1.
- On tb_last: if last_flag → DONE. Otherwise step_cnt←0 → ACS. Path metrics are not cleared between blocks.
- DONE (1 cycle): frame_done=1 → IDLE.
- start outside IDLE is ignored. in_last is ignored unless its pair is accepted.
- A frame with no pairs stays in ACS; there is no abort short of rst.

## Timing
- Reset (async, immediate): state IDLE, all registers 0. All outputs 0, including mem_wr_addr=tb_rd_addr=0, in_ready=0, busy=0.
- start at cycle n: INIT at n+1 (acs_clr), in_ready=1 at n+2.
- Block-closing accept at cycle m: TRACE occupies m+1 … m+tb_len. in_ready=1 again at m+tb_len+1, or frame_done at m+tb_len+1 then busy=0 at m+tb_len+2.
- Full-rate throughput: TB_DEPTH pairs per 2·TB_DEPTH cycles.
- tb_len=1: tb_first and tb_last are high in the same cycle.
- rst mid-frame, any state: everything returns to reset values; the next frame restarts at address 0.

## Test plan
- Reset: assert rst mid-stream → every output 0 the same cycle; busy=0; in_ready=0 until start+2 cycles.
- TB_DEPTH=16, ADDR_W=5: start, 16 back-to-back pairs → mem_wr_addr 0..15 with acs_en each cycle; then 16 TRACE cycles with tb_rd_addr 15..0, tb_first at 15, tb_last at 0, in_ready=0 throughout, in_ready=1 on the next cycle.
- Wrap, TB_DEPTH=12, ADDR_W=4: 24 pairs, in_last on the 24th → block 1 writes 0..11 and reads 11..0; block 2 writes 12..15,0..7 and reads 7..0,15..12; frame_done pulse one cycle after tb_last; busy falls the cycle after.
- in_last on the first pair → single TRACE cycle, tb_rd_addr=0 with tb_first=tb_last=1, then frame_done.
- Gaps/ignores: in_valid toggling 1,0,1 in ACS → only valid cycles advance wr_ptr. in_valid and start during TRACE → no effect. in_valid in IDLE → acs_en=0.
- Async rst during TRACE at tb_cnt=5 → tb_rd_en drops immediately; the following start and pair writes address 0.
